keypad_scan_decoder: RTL and testbench
======================================

Name: keypad_scan_decoder

Overview:
- Downstream consumer of the 4-bit one-hot ring counter.
- The ring counter's q drives the four keypad columns. This block samples the four row lines against the active column and debounces the full 4x4 key matrix per scan frame.
- Each new key press is emitted as a 4-bit key code on a valid/ready interface to the host logic.

Parameters:
- DEB_FRAMES, 4, consecutive identical frames required before a matrix snapshot is accepted as stable (legal range 1..15).
- SYNC_STAGES, 2, flip-flop stages on row_in; the column delay line matches this depth.

Ports:
- clk  input  1  system clock; the same clock as the ring counter.
- clr_n  input  1  asynchronous, active-low reset.
- col_q  input  4  one-hot column drive from the ring counter. Sequence is 1000 -> 0100 -> 0010 -> 0001 -> 1000.
- row_in  input  4  raw row sense, asynchronous; 1 = key closed.
- key_code  output  4  {col_idx[1:0], row_idx[1:0]} of the reported key.
- key_valid  output  1  key_code holds a reportable press.
- key_ready  input  1  consumer accepts key_code on this cycle when key_valid=1.
- col_err  output  1  one-cycle pulse when the delayed col_q is not one-hot.
- stable_map  output  16  current debounced matrix; bit index = {col_idx,row_idx}.

Behaviour:
- Reset (clr_n=0, asynchronous): all registers cleared immediately.
  - key_valid=0, key_code=0, col_err=0, stable_map=0.
  - Synchronizers, delay line, frame buffer, debounce counter and pending mask all 0.
- Row sync: row_in passes through SYNC_STAGES flops (row_s). col_q passes through a SYNC_STAGES-deep delay (col_d), so row_s and col_d refer to the same scan cycle.
- Column index from col_d: 1000->3, 0100->2, 0010->1, 0001->0.
- col_d not one-hot (0000 or more than one bit set): pulse col_err for that cycle and set frame_bad. Nothing from that cycle is written.
- Each cycle with col_d one-hot: write row_s into frame[col_idx*4 +: 4].
- Frame end = cycle in which col_d==0001. On that cycle the completed frame includes the current row_s.
  - frame_bad=1: discard the frame, clear frame_bad, leave the debounce counter unchanged.
  - Completed frame == cand (candidate register): deb_cnt increments, saturating at DEB_FRAMES.
  - Otherwise: cand <= frame, deb_cnt <= 1.
  - When deb_cnt reaches DEB_FRAMES (first frame at which it becomes equal): new_press = cand & ~stable_map. Then stable_map <= cand and pending <= pending | new_press.
  - stable_map therefore updates exactly once per stable change, at a frame end. Key releases clear stable_map bits but generate no output.
- Output stage, one-entry holding register:
  - If key_valid=0 and pending!=0: load key_code with the lowest set index of pending, clear that pending bit, set key_valid. This takes one cycle after pending updates.
  - If key_valid=1 and key_ready=1: the transfer completes. key_valid drops next cycle, unless the same-cycle reload rule applies.
  - Same-cycle reload: if key_valid=1, key_ready=1 and pending!=0, load the next code that cycle and keep key_valid=1.
  - key_code must not change while key_valid=1 and key_ready=0.
- Simultaneous events: a pending OR from a frame end in the same cycle as a dequeue clear must keep both effects. The bit being loaded is cleared; newly set bits are retained.
- Repeated press of a key whose pending bit is already set: no duplicate; the single bit stays set.
- Debounce latency: a clean press is first visible in stable_map at the end of the DEB_FRAMES-th full frame containing it. key_valid rises 1 cycle later if idle.

Decomposition:
- Shared package keypad_pkg holds:
  - KEY_W=4, COLS=4, ROWS=4.
  - Function onehot_idx(4-bit) -> 2-bit index plus valid flag.
  - Function lowest_set(16-bit) -> 4-bit index.
- One natural sub-module: keypad_sync_delay. It contains the row synchronizer plus the matched col_q delay line, parameterized by SYNC_STAGES.

Test Plan:
- Reset sequencing: assert clr_n=0 mid-frame with pending=0x0010 and key_valid=1. Required: all outputs 0 immediately, asynchronously. Release and drive 10 clean frames with no keys: stable_map=0, key_valid never rises.
- Single press: hold row 2 high only while col_q=0100 (key 0xA) for 6 frames, DEB_FRAMES=4. Required: stable_map=0x0400 at end of frame 4; key_valid=1 with key_code=0xA one cycle later; held until key_ready=1.
- Bounce rejection: toggle key 0x5 on alternate frames for 8 frames. Required: stable_map stays 0, no key_valid. Then hold it for 4 frames: key_code=0x5 is reported exactly once.
- Multi-key with backpressure:
  - Press 0x3 and 0xC together, with key_ready=0 for 20 cycles.
  - Required: key_code=0x3 is held stable throughout.
  - Pulse key_ready: next cycle key_code=0xC with key_valid still 1. Second accept: key_valid=0.
- Bad column: force col_q=0110 for one cycle inside a frame. Required: col_err pulses once, 2 cycles later. That frame is discarded and deb_cnt is unchanged; the next clean frame still counts.
- Release then re-press: release 0xA, wait 4 frames (stable_map bit clears, no output), then press again. Required: key_code=0xA is reported a second time.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 keypad scan decoder: matrix dimensions,
// the column-select decode result type and two small helper functions.
//   onehot_idx(col) : decodes a one-hot column drive into a 2-bit index and
//                     flags any pattern that is not exactly one-hot.
//   lowest_set(map) : index of the lowest set bit of a 16-bit key map.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int COLS  = 4;
  localparam int ROWS  = 4;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } col_sel_t;

  function automatic col_sel_t onehot_idx(input logic [COLS-1:0] col);
    col_sel_t r;
    r.valid = 1'b1;
    r.idx   = 2'd0;
    case (col)
      4'b1000: r.idx = 2'd3;
      4'b0100: r.idx = 2'd2;
      4'b0010: r.idx = 2'd1;
      4'b0001: r.idx = 2'd0;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  // Scans downwards so the last hit is the lowest set index.
  function automatic logic [KEY_W-1:0] lowest_set(input logic [COLS*ROWS-1:0] map);
    logic [KEY_W-1:0] r;
    r = '0;
    for (int i = COLS*ROWS-1; i >= 0; i--) begin
      if (map[i]) r = KEY_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_sync_delay.sv
// keypad_sync_delay
// Synchronizes the asynchronous row sense lines and delays the column drive
// by the same number of stages, so row_s and col_d describe the same scan
// cycle.
// Ports:
//   clk, clr_n : clock and asynchronous active-low reset
//   row_in     : raw row sense (asynchronous)
//   col_q      : one-hot column drive from the ring counter
//   row_s      : synchronized rows
//   col_d      : column drive delayed to line up with row_s
module keypad_sync_delay
  import keypad_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic [ROWS-1:0] row_in,
  input  logic [COLS-1:0] col_q,
  output logic [ROWS-1:0] row_s,
  output logic [COLS-1:0] col_d
);

  logic [SYNC_STAGES-1:0][ROWS-1:0] row_pipe;
  logic [SYNC_STAGES-1:0][COLS-1:0] col_pipe;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      row_pipe <= '0;
      col_pipe <= '0;
    end else begin
      row_pipe[0] <= row_in;
      col_pipe[0] <= col_q;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        row_pipe[i] <= row_pipe[i-1];
        col_pipe[i] <= col_pipe[i-1];
      end
    end
  end

  assign row_s = row_pipe[SYNC_STAGES-1];
  assign col_d = col_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder
// Samples the keypad rows against the active column, assembles one 16-bit
// matrix snapshot per scan frame, debounces it over DEB_FRAMES identical
// frames and reports every newly pressed key on a valid/ready interface.
// Ports:
//   clk, clr_n  : clock and asynchronous active-low reset
//   col_q       : one-hot column drive (1000 -> 0100 -> 0010 -> 0001)
//   row_in      : raw row sense, 1 = key closed
//   key_code    : {col_idx, row_idx} of the reported key
//   key_valid   : key_code holds a reportable press
//   key_ready   : consumer accepts key_code when key_valid=1
//   col_err     : one-cycle pulse when the delayed column is not one-hot
//   stable_map  : debounced matrix, bit index = {col_idx, row_idx}
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int DEB_FRAMES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [COLS-1:0]      col_q,
  input  logic [ROWS-1:0]      row_in,
  output logic [KEY_W-1:0]     key_code,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic                 col_err,
  output logic [COLS*ROWS-1:0] stable_map
);

  localparam int                 MAP_W   = COLS*ROWS;
  localparam logic [3:0]         DEB_MAX = 4'(DEB_FRAMES);
  localparam logic [MAP_W-1:0]   ONE     = MAP_W'(1);

  logic [ROWS-1:0]  row_s;
  logic [COLS-1:0]  col_d;
  col_sel_t         col_sel;
  logic             frame_end;

  logic [MAP_W-1:0] frame;
  logic [MAP_W-1:0] frame_done;
  logic             frame_bad;
  logic [MAP_W-1:0] cand;
  logic [MAP_W-1:0] cand_next;
  logic [3:0]       deb_cnt;
  logic [3:0]       cnt_next;
  logic             fire;
  logic [MAP_W-1:0] new_press;

  logic [MAP_W-1:0] pending;
  logic             load;
  logic [KEY_W-1:0] load_idx;
  logic [MAP_W-1:0] load_mask;

  keypad_sync_delay #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .clr_n (clr_n),
    .row_in(row_in),
    .col_q (col_q),
    .row_s (row_s),
    .col_d (col_d)
  );

  assign col_sel   = onehot_idx(col_d);
  assign frame_end = col_sel.valid && (col_sel.idx == 2'd0);

  // The frame-end cycle writes column 0, so the completed snapshot has to
  // include the current row_s rather than the not-yet-written buffer slot.
  always_comb begin
    frame_done           = frame;
    frame_done[ROWS-1:0] = row_s;
  end

  // Debounce decision for a clean frame end; fire marks the single frame at
  // which the count first reaches DEB_FRAMES.
  always_comb begin
    cnt_next  = deb_cnt;
    cand_next = cand;
    fire      = 1'b0;
    if (frame_end && !frame_bad) begin
      if (frame_done == cand) begin
        if (deb_cnt < DEB_MAX) begin
          cnt_next = deb_cnt + 4'd1;
          fire     = (cnt_next == DEB_MAX);
        end
      end else begin
        cand_next = frame_done;
        cnt_next  = 4'd1;
        fire      = (DEB_MAX == 4'd1);
      end
    end
  end

  assign new_press = fire ? (cand_next & ~stable_map) : '0;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      frame      <= '0;
      frame_bad  <= 1'b0;
      cand       <= '0;
      deb_cnt    <= '0;
      stable_map <= '0;
      col_err    <= 1'b0;
    end else begin
      col_err <= !col_sel.valid;
      if (!col_sel.valid) begin
        frame_bad <= 1'b1;
      end else begin
        frame[{col_sel.idx, 2'b00} +: ROWS] <= row_s;
        if (frame_end && frame_bad) frame_bad <= 1'b0;
      end
      cand    <= cand_next;
      deb_cnt <= cnt_next;
      if (fire) stable_map <= cand_next;
    end
  end

  // The holding register refills whenever it is empty or being drained this
  // cycle; a dequeue and a frame-end OR in the same cycle both take effect.
  assign load      = (pending != '0) && (!key_valid || key_ready);
  assign load_idx  = lowest_set(pending);
  assign load_mask = load ? (ONE << load_idx) : '0;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pending   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      pending <= (pending & ~load_mask) | new_press;
      if (load) begin
        key_code  <= load_idx;
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// tb_keypad_scan_decoder
// Drives a simulated 4x4 keypad behind a free-running one-hot column ring
// and checks keypad_scan_decoder with directed scenarios plus a randomized
// run compared against a frame-level reference model.
module tb_keypad_scan_decoder;

  localparam int DEB  = 4;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [3:0]  col_q;
  logic [3:0]  row_in;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        col_err;
  logic [15:0] stable_map;

  keypad_scan_decoder #(
    .DEB_FRAMES (DEB),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .col_q     (col_q),
    .row_in    (row_in),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .col_err   (col_err),
    .stable_map(stable_map)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Keypad / ring-counter stimulus state
  logic [15:0] pressed;
  logic        ready_drv;
  int          ring_idx;
  logic        force_en;
  logic [3:0]  force_val;

  // Reference model state
  logic [3:0]  m_cq[$];
  logic [3:0]  m_rq[$];
  logic [15:0] m_frame, m_cand, m_stable, m_pending;
  int          m_cnt;
  logic        m_bad, m_valid, m_col_err;
  logic [3:0]  m_code;

  // A physical matrix: a row reads 1 if any driven column has a closed key on it.
  function automatic logic [3:0] rows_for(input logic [3:0] cols, input logic [15:0] keys);
    logic [3:0] r;
    r = 4'h0;
    for (int c = 0; c < 4; c++) begin
      if (cols[c]) r = r | keys[c*4 +: 4];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cq.delete();
    m_rq.delete();
    for (int i = 0; i < SYNC; i++) begin
      m_cq.push_back(4'h0);
      m_rq.push_back(4'h0);
    end
    m_frame = '0; m_cand = '0; m_stable = '0; m_pending = '0;
    m_cnt = 0; m_bad = 0; m_valid = 0; m_col_err = 0; m_code = '0;
  endtask

  task automatic model_step(input logic [3:0] col, input logic [3:0] rows, input logic rdy);
    logic [3:0]  cd, rs;
    logic [15:0] newp;
    logic        fire;
    int          ci;
    cd = m_cq.pop_front();
    rs = m_rq.pop_front();
    m_cq.push_back(col);
    m_rq.push_back(rows);
    newp = '0;
    fire = 0;
    ci = 0;
    m_col_err = 0;
    if ($countones(cd) != 1) begin
      m_col_err = 1;
      m_bad = 1;
    end else begin
      for (int i = 0; i < 4; i++) if (cd[i]) ci = i;
      m_frame[ci*4 +: 4] = rs;
      if (ci == 0) begin
        if (m_bad) begin
          m_bad = 0;
        end else if (m_frame == m_cand) begin
          if (m_cnt < DEB) begin
            m_cnt++;
            if (m_cnt == DEB) fire = 1;
          end
        end else begin
          m_cand = m_frame;
          m_cnt = 1;
          if (DEB == 1) fire = 1;
        end
        if (fire) begin
          newp = m_cand & ~m_stable;
          m_stable = m_cand;
        end
      end
    end
    if (m_valid && rdy) m_valid = 0;
    if (!m_valid && m_pending != 0) begin
      for (int i = 15; i >= 0; i--) if (m_pending[i]) m_code = 4'(i);
      m_pending[m_code] = 1'b0;
      m_valid = 1;
    end
    m_pending = m_pending | newp;
  endtask

  // One clock: drive inputs, let the edge happen, step the model, then settle.
  task automatic cycle();
    logic [3:0] cv;
    cv = force_en ? force_val : (4'b0001 << ring_idx);
    col_q = cv;
    row_in = rows_for(cv, pressed);
    key_ready = ready_drv;
    @(posedge clk);
    model_step(cv, row_in, key_ready);
    ring_idx = (ring_idx + 3) % 4;
    force_en = 0;
    #1;
  endtask

  task automatic align();
    while (ring_idx != 3) cycle();
  endtask

  task automatic settle();
    pressed = '0;
    ready_drv = 1;
    repeat (32) cycle();
    align();
  endtask

  task automatic test_reset();
    int w;
    clr_n = 0; pressed = '0; ready_drv = 0; col_q = '0; row_in = '0;
    key_ready = 0; force_en = 0; force_val = '0; ring_idx = 3;
    model_reset();
    #3;
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); end
    n_checks++; if (stable_map !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_stable: got %h expected 0000", stable_map); end
    @(posedge clk); #3 clr_n = 1;
    pressed = 16'h0011;
    w = 0;
    while (!(m_valid && m_pending == 16'h0010) && w < 80) begin cycle(); w++; end
    n_checks++; if (key_valid !== 1'b1 || key_code !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_pre_valid: got %b/%h expected 1/0", key_valid, key_code); end
    while (ring_idx != 1) cycle();
    #2 clr_n = 0;
    #1;
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_valid: got %b expected 0", key_valid); end
    n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("[TB] FAIL async_code: got %h expected 0", key_code); end
    n_checks++; if (col_err !== 1'b0) begin n_fail++; $display("[TB] FAIL async_col_err: got %b expected 0", col_err); end
    n_checks++; if (stable_map !== 16'h0) begin n_fail++; $display("[TB] FAIL async_stable: got %h expected 0000", stable_map); end
    model_reset();
    ring_idx = 3;
    pressed = '0;
    @(posedge clk); @(posedge clk); #3 clr_n = 1;
    for (int k = 0; k < 42; k++) begin
      cycle();
      n_checks++;
      if (key_valid !== 1'b0 || stable_map !== 16'h0) begin
        n_fail++; $display("[TB] FAIL idle_frames: got %b/%h expected 0/0000", key_valid, stable_map);
      end
    end
  endtask

  task automatic test_single_press();
    settle();
    pressed = 16'h0400;
    ready_drv = 0;
    for (int k = 0; k < 24; k++) begin
      cycle();
      if (k == 16) begin
        n_checks++; if (stable_map !== 16'h0) begin n_fail++; $display("[TB] FAIL single_early: got %h expected 0000", stable_map); end
      end
      if (k == 17) begin
        n_checks++; if (stable_map !== 16'h0400) begin n_fail++; $display("[TB] FAIL single_stable: got %h expected 0400", stable_map); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_valid_early: got %b expected 0", key_valid); end
      end
      if (k >= 18) begin
        n_checks++;
        if (key_valid !== 1'b1 || key_code !== 4'hA) begin
          n_fail++; $display("[TB] FAIL single_hold: got %b/%h expected 1/a", key_valid, key_code);
        end
      end
    end
    ready_drv = 1;
    cycle();
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_accept: got %b expected 0", key_valid); end
  endtask

  task automatic test_release_repress();
    int w;
    ready_drv = 1;
    align();
    pressed = '0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL release_no_out: got %b expected 0", key_valid); end
    end
    n_checks++; if (stable_map !== 16'h0) begin n_fail++; $display("[TB] FAIL release_stable: got %h expected 0000", stable_map); end
    align();
    pressed = 16'h0400;
    w = 0;
    while (key_valid !== 1'b1 && w < 40) begin cycle(); w++; end
    n_checks++; if (key_valid !== 1'b1 || key_code !== 4'hA) begin n_fail++; $display("[TB] FAIL repress: got %b/%h expected 1/a", key_valid, key_code); end
    cycle();
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL repress_accept: got %b expected 0", key_valid); end
  endtask

  task automatic test_bounce();
    int seen;
    settle();
    for (int f = 0; f < 8; f++) begin
      pressed = (f % 2 == 0) ? 16'h0020 : 16'h0000;
      repeat (4) begin
        cycle();
        n_checks++;
        if (stable_map !== 16'h0 || key_valid !== 1'b0) begin
          n_fail++; $display("[TB] FAIL bounce_quiet: got %h/%b expected 0000/0", stable_map, key_valid);
        end
      end
    end
    pressed = 16'h0020;
    seen = 0;
    for (int k = 0; k < 46; k++) begin
      cycle();
      if (key_valid === 1'b1) begin
        seen++;
        n_checks++; if (key_code !== 4'h5) begin n_fail++; $display("[TB] FAIL bounce_code: got %h expected 5", key_code); end
      end
    end
    n_checks++; if (seen != 1) begin n_fail++; $display("[TB] FAIL bounce_once: got %0d reports expected 1", seen); end
  endtask

  task automatic test_multi_key();
    int w;
    settle();
    pressed = 16'h1008;
    ready_drv = 0;
    w = 0;
    while (key_valid !== 1'b1 && w < 60) begin cycle(); w++; end
    n_checks++; if (key_valid !== 1'b1 || key_code !== 4'h3) begin n_fail++; $display("[TB] FAIL multi_first: got %b/%h expected 1/3", key_valid, key_code); end
    for (int k = 0; k < 20; k++) begin
      cycle();
      n_checks++;
      if (key_valid !== 1'b1 || key_code !== 4'h3) begin
        n_fail++; $display("[TB] FAIL multi_hold: got %b/%h expected 1/3", key_valid, key_code);
      end
    end
    ready_drv = 1;
    cycle();
    n_checks++; if (key_valid !== 1'b1 || key_code !== 4'hC) begin n_fail++; $display("[TB] FAIL multi_reload: got %b/%h expected 1/c", key_valid, key_code); end
    cycle();
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL multi_drain: got %b expected 0", key_valid); end
  endtask

  task automatic test_bad_column();
    int pulses;
    settle();
    pressed = 16'h0040;
    pulses = 0;
    for (int k = 0; k < 22; k++) begin
      if (k == 5) begin force_en = 1; force_val = 4'b0110; end
      cycle();
      if (col_err === 1'b1) pulses++;
      if (k >= 5 && k <= 8) begin
        n_checks++;
        if (col_err !== (k == 7)) begin
          n_fail++; $display("[TB] FAIL bad_col_err_k%0d: got %b expected %b", k, col_err, (k == 7));
        end
      end
      if (k == 20) begin
        n_checks++; if (stable_map !== 16'h0) begin n_fail++; $display("[TB] FAIL bad_col_early: got %h expected 0000", stable_map); end
      end
      if (k == 21) begin
        n_checks++; if (stable_map !== 16'h0040) begin n_fail++; $display("[TB] FAIL bad_col_stable: got %h expected 0040", stable_map); end
      end
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("[TB] FAIL bad_col_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_random();
    logic [3:0] bad_vals [4];
    int frames;
    bad_vals[0] = 4'b0000; bad_vals[1] = 4'b0110;
    bad_vals[2] = 4'b1111; bad_vals[3] = 4'b1001;
    for (int s = 0; s < 30; s++) begin
      pressed = 16'($urandom & $urandom & $urandom);
      frames = $urandom_range(1, 6);
      for (int k = 0; k < frames*4; k++) begin
        ready_drv = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 49) == 0) begin
          force_en = 1;
          force_val = bad_vals[$urandom_range(0, 3)];
        end
        cycle();
        n_checks++;
        if (stable_map !== m_stable || key_valid !== m_valid || key_code !== m_code || col_err !== m_col_err) begin
          n_fail++;
          $display("[TB] FAIL random_seg%0d: got map=%h v=%b code=%h err=%b expected map=%h v=%b code=%h err=%b",
                   s, stable_map, key_valid, key_code, col_err, m_stable, m_valid, m_code, m_col_err);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_single_press();
    test_release_repress();
    test_bounce();
    test_multi_key();
    test_bad_column();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
